// File: rtl/char_receiver.sv
// 8N1 UART receiver (LSB first, idle-high) with a hold-until-ack byte output, framing-error pulse and sticky overrun.
// Optional build macro RX_MAJORITY_EN: 2-of-3 majority vote at each sample point (needs CLKS_PER_BIT >= 6).
module char_receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       cclk,
  input  logic       rst,
  input  logic       serialIn,
  input  logic       char_ack,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic [2:0]  state;
  logic [15:0] phase;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        sync1;
  logic        rx_s;
  logic        sample;

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge cclk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serialIn;
      rx_s  <= sync1;
    end
  end

`ifdef RX_MAJORITY_EN
  // hist[0] holds rx_s from phase P-1, hist[1] from phase P-2; phase advances every cycle.
  logic [1:0] hist;

  always_ff @(posedge cclk) begin
    if (rst) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge cclk) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= 16'd0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      char_out    <= 8'h00;
      char_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      phase       <= phase + 16'd1;
      if (char_ack && char_valid) begin
        char_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            phase <= 16'd0;
          end
        end

        START: begin
          if (phase == HALF_LAST) begin
            phase <= 16'd0;
            if (sample) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end
        end

        // Right shift lands the first (LSB) bit in bit 0 after eight samples.
        DATA: begin
          if (phase == BIT_LAST) begin
            phase   <= 16'd0;
            shift   <= {sample, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end

        // A new byte always overwrites; an ack in the same cycle cannot clear it.
        STOP: begin
          if (phase == BIT_LAST) begin
            phase <= 16'd0;
            if (sample) begin
              char_out   <= shift;
              char_valid <= 1'b1;
              if (char_valid && !char_ack) begin
                overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              framing_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            phase <= 16'd0;
          end
        end

        default: begin
          state <= IDLE;
          phase <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_receiver.sv
// Scoreboard bench for char_receiver at CLKS_PER_BIT=16: stimulus pushes expected bytes/framing
// events with their arrival edge, a negedge monitor pops and compares them.
module tb_char_receiver;

  localparam int CPB      = 16;
  localparam int HALF     = CPB / 2;
  localparam int STOP_OFS = 2 + HALF + 9 * CPB;

  logic       cclk = 1'b0;
  logic       rst;
  logic       serialIn;
  logic       char_ack;
  logic [7:0] char_out;
  logic       char_valid;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at_cyc;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  bit  auto_ack = 1'b1;
  int  ack_req = 0;
  int  ack_done = 0;

  char_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .cclk       (cclk),
    .rst        (rst),
    .serialIn   (serialIn),
    .char_ack   (char_ack),
    .char_out   (char_out),
    .char_valid (char_valid),
    .framing_err(framing_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 cclk = ~cclk;

  always @(posedge cclk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge cclk);
      #1;
    end
  endtask

  // Each frame bit is held for CPB cycles; glitch inverts the line for the one cycle whose
  // capture feeds the nominal sample point of that bit.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit, input bit glitch);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        serialIn = (glitch && j == HALF) ? ~frame[k] : frame[k];
        step(1);
      end
    end
    serialIn = 1'b1;
  endtask

  task automatic expect_event(input bit is_err, input logic [7:0] data, input int at_cyc);
    ev_t ev;
    ev.is_err = is_err;
    ev.data   = data;
    ev.at_cyc = at_cyc;
    sb.push_back(ev);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) step(1);
    check_output(name, sb.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_char_out"}, char_out, 8'h00);
    check_output({tag, "_char_valid"}, char_valid, 0);
    check_output({tag, "_framing_err"}, framing_err, 0);
    check_output({tag, "_overrun"}, overrun, 0);
    check_output({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: every rising char_valid or framing_err pulse must match the head of the scoreboard.
  initial begin
    logic prev_valid;
    ev_t  ev;
    prev_valid = 1'b0;
    forever begin
      @(negedge cclk);
      if (!rst) begin
        if (char_valid && !prev_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sb_unexpected_byte: got %0h expected none (cyc %0d)", char_out, cyc);
          end else begin
            ev = sb.pop_front();
            check_output("sb_kind_byte", 0, ev.is_err);
            check_output("sb_byte", char_out, ev.data);
            check_output("sb_byte_cycle", cyc, ev.at_cyc);
          end
        end
        if (framing_err) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sb_unexpected_framing_err: got 1 expected 0 (cyc %0d)", cyc);
          end else begin
            ev = sb.pop_front();
            check_output("sb_kind_err", 1, ev.is_err);
            check_output("sb_err_cycle", cyc, ev.at_cyc);
          end
        end
      end
      prev_valid = char_valid;
    end
  end

  // Consumer: acks a held byte two cycles after seeing it, or on explicit request.
  initial begin
    char_ack = 1'b0;
    forever begin
      @(posedge cclk);
      #1;
      if ((auto_ack && char_valid) || ack_req != ack_done) begin
        step(2);
        char_ack = 1'b1;
        step(1);
        char_ack = 1'b0;
        ack_done = ack_req;
      end
    end
  end

  initial begin
    int         e0;
    int         c0;
    int         low_cnt;
    logic [7:0] d;

    rst      = 1'b1;
    serialIn = 1'b1;
    step(4);
    check_reset_values("reset");
    rst = 1'b0;
    step(10);

    $display("[TB] back-to-back 0x41, 0x7A");
    e0 = cyc + 1;
    expect_event(0, 8'h41, e0 + STOP_OFS);
    expect_event(0, 8'h7A, e0 + 10 * CPB + STOP_OFS);
    send_byte(8'h41, 1'b1, 0);
    send_byte(8'h7A, 1'b1, 0);
    step(20);
    wait_drain("b2b_drain");
    check_output("b2b_overrun", overrun, 0);
    check_output("b2b_valid_acked", char_valid, 0);

    $display("[TB] 5-cycle start glitch");
    c0 = cyc;
    serialIn = 1'b0;
    step(3);
    check_output("glitch_busy_rise", busy, 1);
    step(2);
    serialIn = 1'b1;
    while (busy && cyc < c0 + HALF + 3) step(1);
    check_output("glitch_busy_fall", busy, 0);
    check_output("glitch_valid", char_valid, 0);
    check_output("glitch_overrun", overrun, 0);
    step(20);

    $display("[TB] framing error on 0x55 then break");
    e0 = cyc + 1;
    expect_event(1, 8'h00, e0 + STOP_OFS);
    send_byte(8'h55, 1'b0, 0);
    serialIn = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!busy) low_cnt++;
    end
    check_output("break_busy_held", low_cnt, 0);
    check_output("break_valid", char_valid, 0);
    serialIn = 1'b1;
    for (int i = 0; i < 5 && busy; i++) step(1);
    check_output("break_release_busy", busy, 0);
    step(20);
    wait_drain("framing_drain");

    $display("[TB] overrun with 0x12, 0x34");
    auto_ack = 1'b0;
    e0 = cyc + 1;
    expect_event(0, 8'h12, e0 + STOP_OFS);
    send_byte(8'h12, 1'b1, 0);
    check_output("ovr_first_clean", overrun, 0);
    send_byte(8'h34, 1'b1, 0);
    step(2);
    check_output("ovr_flag", overrun, 1);
    check_output("ovr_char_out", char_out, 8'h34);
    check_output("ovr_valid", char_valid, 1);
    ack_req++;
    step(8);
    check_output("ovr_valid_after_ack", char_valid, 0);
    check_output("ovr_sticky", overrun, 1);
    auto_ack = 1'b1;
    wait_drain("ovr_drain");

    $display("[TB] reset during bit 4 of 0xC3");
    d = 8'hC3;
    serialIn = 1'b0;
    step(CPB);
    for (int i = 0; i < 4; i++) begin
      serialIn = d[i];
      step(CPB);
    end
    serialIn = d[4];
    step(HALF);
    rst = 1'b1;
    serialIn = 1'b1;
    step(3);
    check_reset_values("midrst");
    rst = 1'b0;
    step(10);
    e0 = cyc + 1;
    expect_event(0, 8'hA5, e0 + STOP_OFS);
    send_byte(8'hA5, 1'b1, 0);
    step(20);
    wait_drain("midrst_drain");

    // Without voting the start sample sees the pulse, START re-enters one cycle later and every
    // later sample lands one bit late, shifting the stop bit into bit 7.
    $display("[TB] sample-point pulses on 0x96");
    e0 = cyc + 1;
`ifdef RX_MAJORITY_EN
    expect_event(0, 8'h96, e0 + STOP_OFS);
`else
    expect_event(0, 8'hCB, e0 + 9 + STOP_OFS);
`endif
    send_byte(8'h96, 1'b1, 1);
    step(30);
    wait_drain("glitch96_drain");
    check_output("final_overrun_clear", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_receiver.md
# char_receiver

Serial-to-parallel UART receiver for the keyboard/IM link: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It sits directly downstream of the character transmitter on the serial wire and produces whole bytes for the message logic. Output uses a hold-until-acknowledged handshake. It flags framing errors and overruns.

## Interface
- CLKS_PER_BIT, 10417: `cclk` cycles per bit period; legal range 4..65535.
- cclk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- serialIn  input  1  asynchronous serial line; idles high.
- char_out  output  8  last received byte; valid while `char_valid` is 1.
- char_valid  output  1  level; set when a byte completes; cleared by `char_ack`.
- char_ack  input  1  one-cycle consumer acknowledge; ignored when `char_valid` is 0.
- framing_err  output  1  one-cycle pulse when the stop bit samples low.
- overrun  output  1  sticky; set when a byte completes while `char_valid` is still 1; cleared only by `rst`.
- busy  output  1  high in every state except IDLE.

## Operation
- `serialIn` passes through a 2-flop synchronizer. All decisions use the synchronized value (`rx_s`).
- Bit counter width is 16 bits. `HALF = CLKS_PER_BIT/2`, using floor division.
- The phase counter clears to 0 on every state entry and increments every cycle.
- IDLE: if `rx_s` is 0, go to START.
- START: when phase reaches HALF-1, sample the line.
  - 1: glitch; return to IDLE with no flags.
  - 0: go to DATA with bit index 0.
- DATA: when phase reaches CLKS_PER_BIT-1, shift the sample into bit[index] (LSB first) and clear phase.
  - After index 7, go to STOP.
- STOP: when phase reaches CLKS_PER_BIT-1, sample the line.
  - 1: load `char_out` and set `char_valid`. If `char_valid` was already 1 and `char_ack` is not high in the same cycle, set `overrun`; the new byte still overwrites. Go to IDLE.
  - 0: pulse `framing_err`, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s` is 1, then go to IDLE. This prevents a held-low (break) line from producing repeated frames.
- `char_ack` in the same cycle that a new byte loads: the new byte wins and `char_valid` stays 1.
- Reset values: `char_out`=0x00, `char_valid`=0, `framing_err`=0, `overrun`=0, `busy`=0. Synchronizer flops reset to 1. State resets to IDLE.
- Reset asserted mid-frame aborts the frame with no flags. The next frame is detected normally after reset is released.

## Timing
- Edge 0 is the first `cclk` edge that captures `serialIn` low.
- IDLE leaves at edge 2.
- Start sample is taken at edge 2+HALF.
- Data bit i is sampled at edge 2+HALF+(i+1)*CLKS_PER_BIT.
- Stop sample is taken at edge 2+HALF+9*CLKS_PER_BIT. `char_valid`/`framing_err` are visible immediately after that edge.
- `char_valid` falls on the edge after `char_ack` is sampled high.
- `busy` rises after edge 2 and falls after the stop-sample edge. On the framing-error path it falls when WAIT_HIGH exits.
- Back-to-back frames: a start bit beginning immediately after the stop-bit sample point is received correctly.

## Configuration
- `RX_MAJORITY_EN` defined: each sample point uses the 2-of-3 majority of `rx_s` at phase values P-2, P-1 and P, where P is the nominal sample phase. Sample edges are unchanged, and CLKS_PER_BIT must be at least 6.
- Not defined: a single sample of `rx_s` at phase P.

## Test plan
- CLKS_PER_BIT=16; send 0x41 then 0x7A back-to-back, acking each within 5 cycles.
  - Expect `char_out`=0x41 then 0x7A, `char_valid` rising at the computed edges, no flags.
- Drive a 5-cycle low glitch on an idle line.
  - Expect return to IDLE, `char_valid`, `framing_err` and `overrun` stay 0, and `busy` falls within HALF+3 cycles.
- Send 0x55 with the stop bit driven low.
  - Expect one `framing_err` pulse and `char_valid` stays 0.
  - Hold the line low 100 cycles, then release: `busy` stays high until release, with no further pulses.
- Send 0x12 and 0x34 without acking.
  - Expect `overrun`=1, `char_out`=0x34, `char_valid`=1.
  - Ack, then expect `char_valid`=0 and `overrun` still 1.
- Assert `rst` during data bit 4 of 0xC3.
  - Expect all outputs at reset values; the next frame 0xA5 is received as 0xA5.
- With `RX_MAJORITY_EN`, inject a 1-cycle inverted pulse at each sample point of 0x96.
  - Expect 0x96 received.
  - Without the macro, the same stimulus corrupts the byte.
